// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port memory between two requesters,
// with a bounded lock so one port can hold the bus for multi-byte sequences.
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_LOCK     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic                  a_lock,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic                  b_lock,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  owner
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
    localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT
    } state_t;

    state_t           r_state;
    logic             r_last;
    logic             r_lock_hold;
    logic [CNT_W-1:0] r_lock_cnt;
    logic             r_via_lock;
    logic [LAT_W-1:0] r_wait_cnt;

    logic w_any;
    logic w_win;
    logic w_lock_act;
    logic w_via_lock;
    logic w_holder_req;

    // Winner selection from the requests sampled in IDLE; 0 = A, 1 = B.
    always_comb begin
        w_any        = a_req | b_req;
        w_lock_act   = r_lock_hold && (r_lock_cnt < CNT_W'(MAX_LOCK));
        w_holder_req = r_last ? b_req : a_req;
        w_via_lock   = 1'b0;
        w_win        = b_req;
        if (a_req && b_req) begin
            if (w_lock_act) begin
                w_win      = r_last;
                w_via_lock = 1'b1;
            end else begin
                w_win = ~r_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_lock_hold <= 1'b0;
            r_lock_cnt  <= '0;
            r_via_lock  <= 1'b0;
            r_wait_cnt  <= '0;
            a_gnt       <= 1'b0;
            b_gnt       <= 1'b0;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            owner       <= 1'b0;
        end else begin
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            mem_en   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A holder that walks away gives up its lock.
                    if (r_lock_hold && !w_holder_req) begin
                        r_lock_hold <= 1'b0;
                    end
                    if (w_any) begin
                        r_last     <= w_win;
                        owner      <= w_win;
                        r_via_lock <= w_via_lock;
                        mem_en     <= 1'b1;
                        mem_we     <= w_win ? b_we    : a_we;
                        mem_addr   <= w_win ? b_addr  : a_addr;
                        mem_wdata  <= w_win ? b_wdata : a_wdata;
                        a_gnt      <= ~w_win;
                        b_gnt      <= w_win;
                        busy       <= 1'b1;
                        r_state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_lock_hold <= r_last ? b_lock : a_lock;
                    r_lock_cnt  <= r_via_lock ? r_lock_cnt + CNT_W'(1) : '0;
                    if (mem_we) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= LAT_W'(1);
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Memory data is valid in the last wait cycle; hand it to the winner.
                    if (r_wait_cnt == LAT_W'(READ_LATENCY)) begin
                        if (r_last) begin
                            b_rdata  <= mem_rdata;
                            b_rvalid <= 1'b1;
                        end else begin
                            a_rdata  <= mem_rdata;
                            a_rvalid <= 1'b1;
                        end
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + LAT_W'(1);
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus random traffic checked
// cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned RL = 3;
    localparam int unsigned ML = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr, mem_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_we, busy, owner;

    mem_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(RL),
        .MAX_LOCK    (ML)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_lock   (a_lock),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_lock   (b_lock),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .owner    (owner)
    );

    // Memory environment: data valid RL cycles after the access cycle, junk otherwise.
    logic [DW-1:0] mem  [0:65535];
    logic [DW-1:0] pipe [0:RL-1];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : DW'($urandom);
        for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[RL-1];

    // Requester drivers (index 0 = A, 1 = B).
    bit            d_req   [2];
    bit            d_we    [2];
    bit            d_lock  [2];
    logic [AW-1:0] d_addr  [2];
    logic [DW-1:0] d_wdata [2];
    bit            fresh   [2];
    int            req_pct [2];
    int            lock_pct[2];
    bit            auto_drv;

    assign a_req = d_req[0];  assign a_we = d_we[0];  assign a_lock = d_lock[0];
    assign a_addr = d_addr[0]; assign a_wdata = d_wdata[0];
    assign b_req = d_req[1];  assign b_we = d_we[1];  assign b_lock = d_lock[1];
    assign b_addr = d_addr[1]; assign b_wdata = d_wdata[1];

    // Reference model state: absolute cycle stamps for when the arbiter is free.
    logic [DW-1:0] ref_mem [0:65535];
    int            cyc, m_next_idle, m_access_cyc, m_rv_cyc, m_cnt;
    bit            m_rv_pend, m_rv_port, m_last, m_hold, m_won_lock, m_win;
    logic [DW-1:0] m_rv_data;
    logic [1:0]    e_gnt, e_rv;
    logic          e_en, e_we, e_busy, e_owner;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [DW-1:0] e_rdata [2];

    int n_tests, n_fail;
    int gcount[2], rvcount[2], busycount, first_gnt, a_before_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("a_gnt",     32'(a_gnt),     32'(e_gnt[0]));
        check("b_gnt",     32'(b_gnt),     32'(e_gnt[1]));
        check("a_rvalid",  32'(a_rvalid),  32'(e_rv[0]));
        check("b_rvalid",  32'(b_rvalid),  32'(e_rv[1]));
        check("a_rdata",   32'(a_rdata),   32'(e_rdata[0]));
        check("b_rdata",   32'(b_rdata),   32'(e_rdata[1]));
        check("mem_en",    32'(mem_en),    32'(e_en));
        check("mem_we",    32'(mem_we),    32'(e_we));
        check("mem_addr",  32'(mem_addr),  32'(e_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        check("busy",      32'(busy),      32'(e_busy));
        check("owner",     32'(owner),     32'(e_owner));
    endtask

    task automatic model_reset();
        cyc = 0; m_next_idle = 0; m_access_cyc = -1; m_rv_cyc = -1; m_cnt = 0;
        m_rv_pend = 0; m_rv_port = 0; m_last = 1; m_hold = 0; m_won_lock = 0; m_win = 0;
        m_rv_data = '0;
        e_gnt = '0; e_rv = '0; e_en = 0; e_we = 0; e_busy = 0; e_owner = 0;
        e_addr = '0; e_wdata = '0; e_rdata[0] = '0; e_rdata[1] = '0;
    endtask

    // Predict outputs of cycle cyc+1 from the inputs presented during cycle cyc.
    task automatic model_step();
        bit lock_act;
        if (m_access_cyc == cyc) begin
            m_hold = d_lock[m_win];
            m_cnt  = m_won_lock ? m_cnt + 1 : 0;
        end
        e_gnt = '0; e_rv = '0; e_en = 0;
        if (cyc >= m_next_idle) begin
            if (m_hold && !d_req[m_last]) m_hold = 0;
            if (d_req[0] || d_req[1]) begin
                lock_act = m_hold && (m_cnt < ML);
                if (d_req[0] && d_req[1]) begin
                    m_win      = lock_act ? m_last : !m_last;
                    m_won_lock = lock_act;
                end else begin
                    m_win      = d_req[1];
                    m_won_lock = 0;
                end
                m_last       = m_win;
                e_owner      = m_win;
                e_gnt[m_win] = 1'b1;
                e_en         = 1'b1;
                e_we         = d_we[m_win];
                e_addr       = d_addr[m_win];
                e_wdata      = d_wdata[m_win];
                m_access_cyc = cyc + 1;
                if (e_we) begin
                    ref_mem[e_addr] = e_wdata;
                    m_next_idle = cyc + 2;
                end else begin
                    m_next_idle = cyc + 2 + RL;
                    m_rv_pend   = 1;
                    m_rv_cyc    = cyc + 2 + RL;
                    m_rv_port   = m_win;
                    m_rv_data   = ref_mem[e_addr];
                end
            end
        end
        if (m_rv_pend && m_rv_cyc == cyc + 1) begin
            e_rv[m_rv_port]    = 1'b1;
            e_rdata[m_rv_port] = m_rv_data;
            m_rv_pend          = 0;
        end
        e_busy = (cyc + 1 < m_next_idle);
    endtask

    // Hold a command until granted; pick a new one the cycle after the grant.
    task automatic drive();
        logic g;
        for (int p = 0; p < 2; p++) begin
            g = (p == 0) ? a_gnt : b_gnt;
            if (g) begin
                fresh[p] = 1;
            end else if (fresh[p] || !d_req[p]) begin
                fresh[p] = 0;
                if (auto_drv) begin
                    d_req[p]   = ($urandom_range(99) < req_pct[p]);
                    d_we[p]    = 1'($urandom_range(1));
                    d_lock[p]  = ($urandom_range(99) < lock_pct[p]);
                    d_addr[p]  = AW'($urandom_range(63));
                    d_wdata[p] = DW'($urandom);
                end else begin
                    d_req[p] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        drive();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (a_gnt) gcount[0]++;
        if (b_gnt) begin
            if (a_before_b < 0) a_before_b = gcount[0];
            gcount[1]++;
        end
        if (a_rvalid) rvcount[0]++;
        if (b_rvalid) rvcount[1]++;
        if (busy) busycount++;
        if (first_gnt < 0 && (a_gnt || b_gnt)) first_gnt = b_gnt ? 1 : 0;
    endtask

    task automatic clear_counts();
        gcount[0] = 0; gcount[1] = 0; rvcount[0] = 0; rvcount[1] = 0;
        busycount = 0; first_gnt = -1; a_before_b = -1;
    endtask

    task automatic clear_drivers();
        for (int p = 0; p < 2; p++) begin
            d_req[p] = 0; d_we[p] = 0; d_lock[p] = 0; d_addr[p] = '0; d_wdata[p] = '0;
            fresh[p] = 0; req_pct[p] = 0; lock_pct[p] = 0;
        end
        auto_drv = 0;
    endtask

    task automatic reset_release();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
        model_reset();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_drivers();
        reset_release();
    endtask

    task automatic issue(input int p, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input bit lk);
        d_req[p] = 1; d_we[p] = we; d_addr[p] = addr; d_wdata[p] = wd; d_lock[p] = lk;
        fresh[p] = 0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0;
        clear_drivers();
        clear_counts();
        for (int i = 0; i < 65536; i++) mem[i] = DW'($urandom);
        mem[16'h0010] = 8'hC3;
        for (int k = 0; k < RL; k++) pipe[k] = '0;
        do_reset();

        // Single A write.
        clear_counts();
        issue(0, 1, 16'h1234, 8'h5A, 0);
        repeat (6) tick();
        check("t1_a_gnt_count", 32'(gcount[0]), 32'd1);
        check("t1_busy_cycles", 32'(busycount), 32'd1);

        // Single B read: rvalid RL+1 cycles after gnt, A's rdata untouched.
        clear_counts();
        issue(1, 0, 16'h0010, 8'h00, 0);
        repeat (RL + 5) tick();
        check("t2_b_gnt_count", 32'(gcount[1]), 32'd1);
        check("t2_b_rvalid_count", 32'(rvcount[1]), 32'd1);
        check("t2_b_rdata", 32'(b_rdata), 32'hC3);
        check("t2_a_rdata", 32'(a_rdata), 32'h00);
        check("t2_busy_cycles", 32'(busycount), 32'(RL + 1));

        // Both requesting continuously without lock: strict alternation from A.
        do_reset();
        clear_counts();
        auto_drv = 1; req_pct[0] = 100; req_pct[1] = 100;
        repeat (40) tick();
        check("t3_first_gnt_is_a", 32'(first_gnt), 32'd0);
        check("t3_balanced", 32'(gcount[0] - gcount[1] <= 1 && gcount[1] - gcount[0] <= 1), 32'd1);

        // A locks continuously while B waits: 1 + ML grants to A before B.
        do_reset();
        clear_counts();
        auto_drv = 1; req_pct[0] = 100; req_pct[1] = 100; lock_pct[0] = 100;
        for (int i = 0; i < 200 && a_before_b < 0; i++) tick();
        check("t4_a_before_b", 32'(a_before_b), 32'(ML + 1));
        repeat (60) tick();

        // Random traffic.
        do_reset();
        auto_drv = 1; req_pct[0] = 60; req_pct[1] = 60; lock_pct[0] = 30; lock_pct[1] = 30;
        repeat (3000) tick();

        // Reset during the WAIT of an A read.
        do_reset();
        clear_counts();
        issue(0, 0, 16'h0005, 8'h00, 0);
        repeat (RL + 5) tick();
        issue(0, 0, 16'h0006, 8'h00, 0);
        for (int i = 0; i < 10 && !a_gnt; i++) tick();
        check("t6_gnt_seen", 32'(a_gnt), 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_a_gnt", 32'(a_gnt), 32'd0);
        check("t6_rst_b_gnt", 32'(b_gnt), 32'd0);
        check("t6_rst_a_rvalid", 32'(a_rvalid), 32'd0);
        check("t6_rst_b_rvalid", 32'(b_rvalid), 32'd0);
        check("t6_rst_a_rdata", 32'(a_rdata), 32'd0);
        check("t6_rst_b_rdata", 32'(b_rdata), 32'd0);
        check("t6_rst_mem_en", 32'(mem_en), 32'd0);
        check("t6_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_owner", 32'(owner), 32'd0);
        clear_drivers();
        reset_release();
        clear_counts();
        issue(0, 0, 16'h0007, 8'h00, 0);
        issue(1, 1, 16'h0008, 8'hAA, 0);
        repeat (15) tick();
        check("t6_first_gnt_is_a", 32'(first_gnt), 32'd0);
        check("t6_a_rvalid_count", 32'(rvcount[0]), 32'd1);
        check("t6_b_gnt_count", 32'(gcount[1]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter for the single-port 8-bit main memory.
- Port A is the CPU control FSM (fetch/execute accesses). Port B is the program loader / debug port that writes and reads memory from switches and buttons.
- Grants one access at a time and drives the memory enable, mode, address and write data. Returns read data to the winner after a fixed memory latency.
- Round-robin fairness, with an optional bounded bus lock for multi-byte sequences (e.g. 16-bit pointer loads).

Parameters:
- DATA_WIDTH, 8, data width of memory and both ports.
- ADDR_WIDTH, 16, address width.
- READ_LATENCY, 1, cycles from memory access cycle to valid mem_rdata; legal 1..4.
- MAX_LOCK, 4, maximum consecutive locked grants to one port while the other is requesting; legal 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req / b_req  in  1  access request; held with command stable until gnt.
- a_we / b_we  in  1  1 = write, 0 = read.
- a_lock / b_lock  in  1  request the next arbitration for the same port.
- a_addr / b_addr  in  ADDR_WIDTH  access address.
- a_wdata / b_wdata  in  DATA_WIDTH  write data.
- a_gnt / b_gnt  out  1  one-cycle pulse: command accepted, memory access this cycle.
- a_rvalid / b_rvalid  out  1  one-cycle pulse: read data valid.
- a_rdata / b_rdata  out  DATA_WIDTH  read data, held until that port's next rvalid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory mode, 1 = write.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  0 = A, 1 = B; last granted port.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - All outputs 0, including rdata registers and owner.
  - Round-robin pointer: last = B, so A wins the first tie.
  - Lock counter 0.
  - Reset mid-access aborts it: no rvalid is produced, and a pending write may or may not have reached memory.
- States: IDLE, ACCESS, WAIT.
- IDLE:
  - Winner selection, evaluated on sampled req:
    - Only one port requesting: that port wins.
    - Both requesting: the port other than `last` wins, except while a lock is active.
    - Lock active means lock_hold = 1 (set when the previous grant had its lock input high) and lock_cnt < MAX_LOCK; the holder (`last`) then wins.
  - On a winner, register its addr, we and wdata; set last = owner = winner; go to ACCESS.
  - Nothing requesting: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_en = 1, with mem_we, mem_addr and mem_wdata from the registered command.
  - The winner's gnt = 1.
  - lock_hold is updated from the winner's lock input, sampled this cycle.
  - lock_cnt increments if the grant was won via lock while the other port requested; otherwise it clears to 0.
  - Write: next state IDLE.
  - Read: next state WAIT.
- WAIT:
  - Lasts READ_LATENCY cycles.
  - In the last WAIT cycle, mem_rdata is registered into the winner's rdata.
  - rvalid pulses the following cycle, i.e. READ_LATENCY+1 cycles after gnt. The state is IDLE in that cycle.
- Timing and throughput:
  - The requester must deassert req in the cycle after gnt unless it wants another access. A req still high at IDLE re-arbitrates.
  - Minimum request-to-gnt latency is 1 cycle.
  - Throughput: a write takes 2 cycles per access; a read takes READ_LATENCY+2.
- Outside ACCESS, mem_en = 0 and the mem_* outputs hold their last values.
- lock_hold clears if the holder is not requesting at an IDLE arbitration.
- At lock_cnt == MAX_LOCK with the other port waiting, the other port wins and lock_cnt clears.
- a_rdata and b_rdata are independent; one port's read never disturbs the other's rdata.
- A request changing while not granted is legal; only the value sampled at the IDLE arbitration edge counts.

Test Plan:
- Reset, then A write addr 0x1234 data 0x5A → ACCESS cycle shows mem_en=1, mem_we=1, mem_addr=0x1234, mem_wdata=0x5A; a_gnt pulses once; busy=1 for 1 cycle.
- B read 0x0010 with mem_rdata=0xC3, READ_LATENCY=1 → b_gnt at T, b_rvalid at T+2 with b_rdata=0xC3; a_rdata stays 0x00.
- A and B requesting continuously, no lock → grants alternate A,B,A,B starting with A after reset; owner toggles accordingly.
- A with a_lock=1, B requesting, MAX_LOCK=4 → A granted 5 times (1 initial + 4 locked), then B granted; lock_cnt returns to 0.
- rst_n asserted during WAIT of an A read → all outputs 0 immediately; no a_rvalid after release; next arbitration favours A.
- READ_LATENCY=3, back-to-back A reads 0x0001 and 0x0002 → gnts 5 cycles apart, each rvalid 4 cycles after its gnt with matching data.
